fp64_to_fixp64: RTL and testbench

FP64_TO_FIXP64 -- requirements
Module: fp64_to_fixp64

---
 rtl/fixp_pkg.sv | 23 ++
 rtl/fp64_classify.sv | 30 +++
 rtl/fp64_to_fixp64.sv | 151 +++++++++++++++
 tb/tb_fp64_to_fixp64.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fixp_pkg.sv
// Shared constants and types for the binary64 -> signed fixed-point converter.
// Ports: none (package). Holds binary64 field widths, exponent bias and all-ones
// exponent code, Q32.32 saturation words and the {nan, ovf} status struct.
package fixp_pkg;

  localparam int FP64_W     = 64;
  localparam int FP64_EXP_W = 11;
  localparam int FP64_MAN_W = 52;

  localparam int                  EXP_BIAS = 1023;
  localparam logic [FP64_EXP_W-1:0] EXP_MAX  = 11'h7FF;

  // Saturation words for a 64-bit signed fixed-point result.
  localparam logic [63:0] Q_SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q_SAT_NEG = 64'h8000_0000_0000_0000;

  // Status carried alongside each output beat, packed as {nan, ovf}.
  typedef struct packed {
    logic nan;
    logic ovf;
  } fix_flags_t;

endpackage

// File: rtl/fp64_classify.sv
// Combinational unpack and classification of an IEEE-754 binary64 operand.
// Ports: d (operand in); sign, exp, mant (hidden bit restored; zero for
// zero/subnormal exponent), is_zero (exp==0, subnormals included), is_nan, is_inf.
module fp64_classify
  import fixp_pkg::*;
(
  input  logic [FP64_W-1:0]     d,
  output logic                  sign,
  output logic [FP64_EXP_W-1:0] exp,
  output logic [FP64_MAN_W:0]   mant,
  output logic                  is_zero,
  output logic                  is_nan,
  output logic                  is_inf
);

  logic [FP64_MAN_W-1:0] frac;
  logic                  exp_max;

  assign sign    = d[63];
  assign exp     = d[62:52];
  assign frac    = d[51:0];
  assign exp_max = (exp == EXP_MAX);

  // Subnormals are flushed, so the hidden bit doubles as "exponent nonzero".
  assign mant    = {(exp != '0), frac};
  assign is_zero = (exp == '0);
  assign is_nan  = exp_max & (frac != '0);
  assign is_inf  = exp_max & (frac == '0);

endmodule

// File: rtl/fp64_to_fixp64.sv
// Three-stage binary64 -> signed Q(INT_W).(FRAC_W) converter with truncation and saturation.
// Ports: clk, rst (sync, active-high); s_tvalid/s_tready/s_tdata input stream;
// m_tvalid/m_tready/m_tdata output stream; m_tuser = {nan, ovf} for the current beat.
// Latency is three clock edges counting the accepting edge; one global enable stalls the whole pipe.
module fp64_to_fixp64
  import fixp_pkg::*;
#(
  parameter int INT_W  = 32,
  parameter int FRAC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [FP64_W-1:0] s_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [63:0]       m_tdata,
  output logic [1:0]        m_tuser
);

  // Unbiased exponent range that needs the barrel shifter. Below K_MIN the
  // result truncates to zero; above K_MAX it always overflows.
  localparam logic signed [12:0] K_MIN = 13'(-FRAC_W - 1);
  localparam logic signed [12:0] K_MAX = 13'(INT_W - 1);
  // Left-shift amount is k + FRAC_W + 1, which maps [K_MIN, K_MAX] onto [0, 64].
  localparam logic signed [12:0] K_OFF = 13'(FRAC_W + 1);

  logic en;
  assign en       = ~m_tvalid | m_tready;
  assign s_tready = en;

  // ---------------- S1: unpack / classify ----------------
  logic                  c_sign;
  logic [FP64_EXP_W-1:0] c_exp;
  logic [FP64_MAN_W:0]   c_mant;
  logic                  c_zero;
  logic                  c_nan;
  logic                  c_inf;
  logic signed [12:0]    c_k;

  fp64_classify u_classify (
    .d       (s_tdata),
    .sign    (c_sign),
    .exp     (c_exp),
    .mant    (c_mant),
    .is_zero (c_zero),
    .is_nan  (c_nan),
    .is_inf  (c_inf)
  );

  assign c_k = $signed({2'b00, c_exp}) - $signed(13'(EXP_BIAS));

  logic                s1_vld;
  logic                s1_sign;
  logic signed [12:0]  s1_k;
  logic [FP64_MAN_W:0] s1_mant;
  logic                s1_zero;
  logic                s1_nan;
  logic                s1_inf;

  // ---------------- S2: align shift ----------------
  logic         k_lo;
  logic         k_hi;
  logic [6:0]   sh;
  logic [127:0] ext;
  logic [63:0]  mag_d;
  logic         sat_d;

  assign k_lo = (s1_k < K_MIN);
  assign k_hi = (s1_k > K_MAX);
  // Shift amount is forced to 0 outside the valid window so it never exceeds 64.
  assign sh   = (k_lo | k_hi) ? 7'd0 : 7'(s1_k + K_OFF);
  assign ext  = {75'd0, s1_mant};

  // mant * 2^(k-52+FRAC_W) == (mant << (k+FRAC_W+1)) >> 53; the right shift truncates toward zero.
  assign mag_d = (s1_zero | s1_nan | s1_inf | k_lo | k_hi) ? 64'd0 : 64'((ext << sh) >> 53);
  assign sat_d = ~s1_nan & (s1_inf | k_hi);

  logic        s2_vld;
  logic        s2_sign;
  logic [63:0] s2_mag;
  logic        s2_nan;
  logic        s2_sat;

  // ---------------- S3: round / negate / saturate ----------------
  logic        neg_min;
  logic        ovf_d;
  logic [63:0] res_d;
  fix_flags_t  flags_d;
  fix_flags_t  flags_q;

  // -2^(INT_W-1) is representable; the same magnitude with a positive sign is not.
  assign neg_min = s2_sign & (s2_mag[62:0] == '0);
  assign ovf_d   = ~s2_nan & (s2_sat | (s2_mag[63] & ~neg_min));

  always_comb begin
    res_d = s2_sign ? (~s2_mag + 64'd1) : s2_mag;
    if (s2_nan) begin
      res_d = 64'd0;
    end else if (ovf_d) begin
      res_d = s2_sign ? Q_SAT_NEG : Q_SAT_POS;
    end
  end

  assign flags_d.nan = s2_nan;
  assign flags_d.ovf = ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_k     <= '0;
      s1_mant  <= '0;
      s1_zero  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s2_vld   <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mag   <= '0;
      s2_nan   <= 1'b0;
      s2_sat   <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      flags_q  <= '0;
    end else if (en) begin
      s1_vld  <= s_tvalid;
      s1_sign <= c_sign;
      s1_k    <= c_k;
      s1_mant <= c_mant;
      s1_zero <= c_zero;
      s1_nan  <= c_nan;
      s1_inf  <= c_inf;

      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_mag  <= mag_d;
      s2_nan  <= s1_nan;
      s2_sat  <= sat_d;

      m_tvalid <= s2_vld;
      if (s2_vld) begin
        m_tdata <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign m_tuser = flags_q;

endmodule

// File: tb/tb_fp64_to_fixp64.sv
// Directed bench for fp64_to_fixp64: table of binary64 inputs with expected Q32.32 words and flags.
// Ports: none (top-level bench); drives clk, rst and both streams of the DUT.
// Adds back-to-back streaming, backpressure and mid-flight reset sequences.
module tb_fp64_to_fixp64;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic [1:0]  m_tuser;

  fp64_to_fixp64 #(.INT_W(32), .FRAC_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dout;
    logic [1:0]  user;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Presents one beat with an idle pipe, returns the result and edges-to-valid
  // (accepting edge counts as 1), then lets the result be consumed.
  task automatic send_one(input logic [63:0] d, output logic [63:0] dat,
                          output logic [1:0] usr, output int lat);
    s_tvalid = 1'b1;
    s_tdata  = d;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    lat = 1;
    while (!m_tvalid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    dat = m_tdata;
    usr = m_tuser;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] dat;
    logic [1:0]  usr;
    int          lat;
    int          idx;
    int          got;
    int          spurious;
    logic        will_acc;

    vecs[0]  = '{64'h3FF8000000000000, 64'h0000000180000000, 2'b00}; // 1.5
    vecs[1]  = '{64'hC002000000000000, 64'hFFFFFFFDC0000000, 2'b00}; // -2.25
    vecs[2]  = '{64'h3D70000000000000, 64'h0000000000000000, 2'b00}; // 2^-40
    vecs[3]  = '{64'h41E0000000000000, 64'h7FFFFFFFFFFFFFFF, 2'b01}; // 2^31
    vecs[4]  = '{64'hC1E0000000000000, 64'h8000000000000000, 2'b00}; // -2^31 exact
    vecs[5]  = '{64'hFFF0000000000000, 64'h8000000000000000, 2'b01}; // -Inf
    vecs[6]  = '{64'h7FF8000000000000, 64'h0000000000000000, 2'b10}; // NaN
    vecs[7]  = '{64'h0000000000000000, 64'h0000000000000000, 2'b00}; // +0
    vecs[8]  = '{64'h8000000000000000, 64'h0000000000000000, 2'b00}; // -0
    vecs[9]  = '{64'h800FFFFFFFFFFFFF, 64'h0000000000000000, 2'b00}; // -subnormal
    vecs[10] = '{64'h3DF0000000000000, 64'h0000000000000001, 2'b00}; // 2^-32
    vecs[11] = '{64'h3DE0000000000000, 64'h0000000000000000, 2'b00}; // 2^-33
    vecs[12] = '{64'h41DFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFC00, 2'b00}; // 2^31-2^-22
    vecs[13] = '{64'hC1E0000000000001, 64'h8000000000000000, 2'b01}; // just below -2^31
    vecs[14] = '{64'h7FF0000000000000, 64'h7FFFFFFFFFFFFFFF, 2'b01}; // +Inf
    vecs[15] = '{64'hBFF0000000000001, 64'hFFFFFFFF00000000, 2'b00}; // -(1+2^-52)
    vecs[16] = '{64'hFFF8000000000001, 64'h0000000000000000, 2'b10}; // negative NaN
    vecs[17] = '{64'h4270000000000000, 64'h7FFFFFFFFFFFFFFF, 2'b01}; // 2^40
    vecs[18] = '{64'hBDF0000000000000, 64'hFFFFFFFFFFFFFFFF, 2'b00}; // -2^-32
    vecs[19] = '{64'h400921FB54442D18, 64'h00000003243F6A88, 2'b00}; // pi

    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_tuser", 64'(m_tuser), 64'd0);
    rst = 1'b0;
    chk("rst_s_tready", 64'(s_tready), 64'd1);

    // Single beats through an idle pipe.
    for (int i = 0; i < NV; i++) begin
      send_one(vecs[i].din, dat, usr, lat);
      chk($sformatf("vec%0d_data", i), dat, vecs[i].dout);
      chk($sformatf("vec%0d_user", i), 64'(usr), 64'(vecs[i].user));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
    end

    // Back-to-back stream at one beat per cycle.
    got = 0;
    for (int c = 0; c < 16; c++) begin
      if (m_tvalid) begin
        if (got < 8) begin
          chk($sformatf("stream%0d_data", got), m_tdata, vecs[got + 10].dout);
          chk($sformatf("stream%0d_user", got), 64'(m_tuser), 64'(vecs[got + 10].user));
        end
        got++;
      end
      s_tvalid = (c < 8);
      s_tdata  = (c < 8) ? vecs[c + 10].din : 64'd0;
      if (c < 8) chk($sformatf("stream%0d_tready", c), 64'(s_tready), 64'd1);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    chk("stream_count", 64'(got), 64'd8);

    // Backpressure: stalled sink, continuous source.
    m_tready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      s_tvalid = 1'b1;
      s_tdata  = vecs[idx].din;
      will_acc = s_tready;
      @(posedge clk); #1;
      if (will_acc) idx++;
      if (c >= 2) chk($sformatf("bp_hold%0d", c), m_tdata, vecs[0].dout);
    end
    s_tvalid = 1'b0;
    chk("bp_accepted", 64'(idx), 64'd3);
    chk("bp_tready_low", 64'(s_tready), 64'd0);
    chk("bp_m_tvalid", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (m_tvalid) begin
        if (got < 3) begin
          chk($sformatf("bp_drain%0d_data", got), m_tdata, vecs[got].dout);
          chk($sformatf("bp_drain%0d_user", got), 64'(m_tuser), 64'(vecs[got].user));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    chk("bp_drain_count", 64'(got), 64'd3);

    // Reset with three beats held in the pipe; the source keeps offering during reset.
    m_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_tvalid = 1'b1;
      s_tdata  = vecs[3 + c].din;
      @(posedge clk); #1;
    end
    s_tdata = vecs[0].din;
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    s_tvalid = 1'b0;
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_m_tdata", m_tdata, 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd1);
    m_tready = 1'b1;
    spurious = 0;
    repeat (8) begin
      if (m_tvalid) spurious++;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_ghost_beats", 64'(spurious), 64'd0);
    send_one(vecs[19].din, dat, usr, lat);
    chk("post_rst_data", dat, vecs[19].dout);
    chk("post_rst_latency", 64'(lat), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
